// File: rtl/capture_pkg.sv
`default_nettype none
// ============================================================================
// capture_pkg
//   State encoding and width helpers shared by the capture buffer files.
//   Revision: 1.0
// ============================================================================
package capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_DONE    = 2'd2,
        ST_READOUT = 2'd3
    } state_e;

    // Word counts must represent DEPTH itself, hence one bit wider than an address.
    function automatic int count_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/capture_buffer_if.sv
`default_nettype none
// ============================================================================
// capture_buffer_if
//   Capture sink, readout source and register-block control/status bundle.
//   Revision: 1.0
// ============================================================================
interface capture_buffer_if #(
    parameter int DW         = 32,
    parameter int DEPTH_LOG2 = 12
);
    import capture_pkg::*;

    localparam int CW = count_width(DEPTH_LOG2);

    logic              S_AXIS_TREADY;
    logic [DW-1:0]     S_AXIS_TDATA;
    logic [DW/8-1:0]   S_AXIS_TSTRB;
    logic              S_AXIS_TLAST;
    logic              S_AXIS_TVALID;

    logic              M_AXIS_TVALID;
    logic [DW-1:0]     M_AXIS_TDATA;
    logic [DW/8-1:0]   M_AXIS_TSTRB;
    logic              M_AXIS_TLAST;
    logic              M_AXIS_TREADY;

    logic              arm;
    logic              readout_start;
    logic [CW-1:0]     capture_count;
    logic              overflow;
    logic [1:0]        state;

    modport slave (
        output S_AXIS_TREADY,
        input  S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, S_AXIS_TVALID,
        output M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST,
        input  M_AXIS_TREADY,
        input  arm, readout_start,
        output capture_count, overflow, state
    );

    modport master (
        input  S_AXIS_TREADY,
        output S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, S_AXIS_TVALID,
        input  M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST,
        output M_AXIS_TREADY,
        output arm, readout_start,
        input  capture_count, overflow, state
    );

endinterface
`default_nettype wire

// File: rtl/capture_bram.sv
`default_nettype none
// ============================================================================
// capture_bram
//   Simple dual-port RAM: one write port, one registered read port.
//   Revision: 1.0
// ============================================================================
module capture_bram #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 12
) (
    input  wire                  clk,
    input  wire                  wr_en_i,
    input  wire [DEPTH_LOG2-1:0] wr_addr_i,
    input  wire [WIDTH-1:0]      wr_data_i,
    input  wire                  rd_en_i,
    input  wire [DEPTH_LOG2-1:0] rd_addr_i,
    output logic [WIDTH-1:0]     rd_data_o
);

    logic [WIDTH-1:0] mem_q [0:(1 << DEPTH_LOG2) - 1];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/capture_buffer.sv
`default_nettype none
// ============================================================================
// capture_buffer
//   Stores one TLAST-terminated packet in RAM and replays it on demand.
//   Revision: 1.0
// ============================================================================
module capture_buffer
    import capture_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int C_DEPTH_LOG2         = 12
) (
    input  wire             S_AXIS_ACLK,
    input  wire             S_AXIS_ARESET,
    capture_buffer_if.slave bus
);

    localparam int CW    = count_width(C_DEPTH_LOG2);
    localparam int DEPTH = 1 << C_DEPTH_LOG2;

    state_e                          state_q, state_d;
    logic [C_DEPTH_LOG2-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]                   count_q, count_d;
    logic                            ovf_q, ovf_d;
    logic [CW-1:0]                   rd_ptr_q, rd_ptr_d;
    logic                            pend_q, pend_d;
    logic                            pend_last_q, pend_last_d;
    logic                            out_valid_q, out_valid_d;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                            out_last_q, out_last_d;
    logic                            skid_valid_q, skid_valid_d;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                            skid_last_q, skid_last_d;

    logic                            w_wr_en;
    logic                            w_rd_en;
    logic                            w_issue;
    logic [CW-1:0]                   w_issue_ptr;
    logic                            w_pop;
    logic [2:0]                      w_fill;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] w_rd_data;
    logic                            w_unused_tstrb;

    assign w_unused_tstrb = ^bus.S_AXIS_TSTRB;
    assign w_pop          = out_valid_q & bus.M_AXIS_TREADY;
    // Words held or in flight after this edge; a new read may only be issued
    // if its data is guaranteed a slot when it lands next cycle.
    assign w_fill = {2'b00, out_valid_q} + {2'b00, skid_valid_q}
                  + {2'b00, pend_q} - {2'b00, w_pop};

    capture_bram #(
        .WIDTH      (C_S_AXIS_TDATA_WIDTH),
        .DEPTH_LOG2 (C_DEPTH_LOG2)
    ) u_bram (
        .clk        (S_AXIS_ACLK),
        .wr_en_i    (w_wr_en),
        .wr_addr_i  (wr_ptr_q),
        .wr_data_i  (bus.S_AXIS_TDATA),
        .rd_en_i    (w_rd_en),
        .rd_addr_i  (w_issue_ptr[C_DEPTH_LOG2-1:0]),
        .rd_data_o  (w_rd_data)
    );

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        rd_ptr_d     = rd_ptr_q;
        pend_last_d  = pend_last_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        w_wr_en      = 1'b0;
        w_issue      = 1'b0;
        w_issue_ptr  = rd_ptr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.arm) begin
                    state_d  = ST_ARMED;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                end
            end
            ST_ARMED: begin
                if (bus.arm) begin
                    wr_ptr_d = '0;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                end else if (bus.S_AXIS_TVALID) begin
                    w_wr_en = 1'b1;
                    if (bus.S_AXIS_TLAST) begin
                        state_d = ST_DONE;
                        count_d = {1'b0, wr_ptr_q} + 1'b1;
                    end else if (&wr_ptr_q) begin
                        state_d = ST_DONE;
                        count_d = CW'(DEPTH);
                        ovf_d   = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (bus.arm) begin
                    state_d  = ST_ARMED;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                end else if (bus.readout_start) begin
                    // Word 0 is fetched in the start cycle to meet the 2-cycle latency.
                    state_d     = ST_READOUT;
                    w_issue     = 1'b1;
                    w_issue_ptr = '0;
                end
            end
            ST_READOUT: begin
                w_issue = (rd_ptr_q < count_q) && (w_fill <= 3'd1);
                if (w_pop && out_last_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        w_rd_en = w_issue;
        pend_d  = w_issue;
        if (w_issue) begin
            rd_ptr_d    = w_issue_ptr + 1'b1;
            pend_last_d = ((w_issue_ptr + 1'b1) == count_q);
        end

        if (!out_valid_q || w_pop) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_last_d   = skid_last_q;
                skid_valid_d = pend_q;
                skid_data_d  = w_rd_data;
                skid_last_d  = pend_q & pend_last_q;
            end else begin
                out_valid_d  = pend_q;
                out_data_d   = w_rd_data;
                out_last_d   = pend_q & pend_last_q;
            end
        end else if (pend_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = w_rd_data;
            skid_last_d  = pend_last_q;
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            rd_ptr_q     <= '0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            rd_ptr_q     <= rd_ptr_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
        end
    end

    assign bus.S_AXIS_TREADY = 1'b1;
    assign bus.M_AXIS_TVALID = out_valid_q;
    assign bus.M_AXIS_TDATA  = out_data_q;
    assign bus.M_AXIS_TSTRB  = '1;
    assign bus.M_AXIS_TLAST  = out_valid_q & out_last_q;
    assign bus.capture_count = count_q;
    assign bus.overflow      = ovf_q;
    assign bus.state         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_capture_buffer.sv
`default_nettype none
// ============================================================================
// tb_capture_buffer
//   Self-checking bench for capture_buffer (DEPTH = 16).
//   Revision: 1.0
// ============================================================================
module tb_capture_buffer;

    localparam int DW    = 32;
    localparam int LOG2  = 4;
    localparam int DEPTH = 16;
    localparam logic [5:0] PAT = 6'b101001;

    typedef struct {
        logic        arm;
        logic        rs;
        logic        tv;
        logic [31:0] td;
        logic        tl;
        logic [1:0]  st;
        logic [4:0]  cnt;
        logic        ovf;
        logic        ov;
        logic [31:0] od;
        logic        ol;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    logic [31:0] got_d [$];
    logic        got_l [$];
    vec_t        tbl   [$];

    always #5 clk = ~clk;

    capture_buffer_if #(.DW(DW), .DEPTH_LOG2(LOG2)) bus ();

    capture_buffer #(
        .C_S_AXIS_TDATA_WIDTH (DW),
        .C_M_AXIS_TDATA_WIDTH (DW),
        .C_DEPTH_LOG2         (LOG2)
    ) dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (rst),
        .bus           (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic a, input logic rs, input logic tv,
                       input logic [31:0] td, input logic tl);
        bus.arm           = a;
        bus.readout_start = rs;
        bus.S_AXIS_TVALID = tv;
        bus.S_AXIS_TDATA  = td;
        bus.S_AXIS_TLAST  = tl;
        tick();
        bus.arm           = 1'b0;
        bus.readout_start = 1'b0;
        bus.S_AXIS_TVALID = 1'b0;
        bus.S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic chk_status(input string name, input logic [1:0] st,
                              input logic [4:0] cnt, input logic ovf);
        chk({name, "_state"}, 32'(bus.state), 32'(st));
        chk({name, "_count"}, 32'(bus.capture_count), 32'(cnt));
        chk({name, "_overflow"}, 32'(bus.overflow), 32'(ovf));
    endtask

    function automatic void add(input logic a, input logic rs, input logic tv,
                                input logic [31:0] td, input logic tl, input logic [1:0] st,
                                input logic [4:0] cnt, input logic ov,
                                input logic [31:0] od, input logic ol);
        vec_t v;
        v.arm = a; v.rs = rs; v.tv = tv; v.td = td; v.tl = tl;
        v.st = st; v.cnt = cnt; v.ovf = 1'b0; v.ov = ov; v.od = od; v.ol = ol;
        tbl.push_back(v);
    endfunction

    // mode 0: ready always high, 1: fixed 1,0,0,1,0,1 pattern, 2: random ready
    // with ignored arm/readout_start pulses sprinkled in.
    task automatic readout(input int mode, input int n_exp);
        int          cycles;
        logic        pv;
        logic [31:0] pd;
        logic        pl;
        cycles = 0;
        pv     = 1'b0;
        pd     = '0;
        pl     = 1'b0;
        got_d.delete();
        got_l.delete();
        bus.M_AXIS_TREADY = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
        while (got_d.size() < n_exp && cycles < 400) begin
            case (mode)
                0:       bus.M_AXIS_TREADY = 1'b1;
                1:       bus.M_AXIS_TREADY = PAT[cycles % 6];
                default: bus.M_AXIS_TREADY = 1'($urandom_range(0, 1));
            endcase
            if (mode == 2) begin
                bus.arm           = ($urandom_range(0, 7) == 0);
                bus.readout_start = ($urandom_range(0, 7) == 0);
            end
            if (pv) begin
                chk("hold_valid", 32'(bus.M_AXIS_TVALID), 32'd1);
                chk("hold_data", bus.M_AXIS_TDATA, pd);
                chk("hold_last", 32'(bus.M_AXIS_TLAST), 32'(pl));
            end
            pv = bus.M_AXIS_TVALID && !bus.M_AXIS_TREADY;
            pd = bus.M_AXIS_TDATA;
            pl = bus.M_AXIS_TLAST;
            if (bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
                got_d.push_back(bus.M_AXIS_TDATA);
                got_l.push_back(bus.M_AXIS_TLAST);
            end
            tick();
            bus.arm           = 1'b0;
            bus.readout_start = 1'b0;
            cycles++;
        end
        chk("readout_words", 32'(got_d.size()), 32'(n_exp));
        chk("readout_end_state", 32'(bus.state), 32'd2);
        chk("readout_end_valid", 32'(bus.M_AXIS_TVALID), 32'd0);
        bus.M_AXIS_TREADY = 1'b1;
    endtask

    task automatic cmp_pkt(input string name, input logic [31:0] exp_q [$]);
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            chk($sformatf("%s_data%0d", name, i), got_d[i], exp_q[i]);
            chk($sformatf("%s_last%0d", name, i), 32'(got_l[i]), 32'(i == exp_q.size() - 1));
        end
    endtask

    initial begin
        logic [31:0] exp_q [$];
        logic [31:0] sent  [$];
        int          len, n, hs, guard;
        logic        has_last, exp_ovf;
        logic [31:0] d;

        bus.arm           = 1'b0;
        bus.readout_start = 1'b0;
        bus.S_AXIS_TVALID = 1'b0;
        bus.S_AXIS_TDATA  = '0;
        bus.S_AXIS_TLAST  = 1'b0;
        bus.S_AXIS_TSTRB  = '1;
        bus.M_AXIS_TREADY = 1'b1;

        // Capture 0x10..0x14 then replay twice; stray beats/starts in IDLE/DONE ignored.
        add(0, 1, 0, 32'h0,  0, 2'd0, 5'd0, 0, 32'h0,  0);
        add(0, 0, 1, 32'h99, 1, 2'd0, 5'd0, 0, 32'h0,  0);
        add(1, 0, 0, 32'h0,  0, 2'd1, 5'd0, 0, 32'h0,  0);
        for (int i = 0; i < 4; i++)
            add(0, 0, 1, 32'h10 + 32'(i), 0, 2'd1, 5'd0, 0, 32'h0, 0);
        add(0, 0, 1, 32'h14, 1, 2'd2, 5'd5, 0, 32'h0,  0);
        add(0, 0, 1, 32'h77, 1, 2'd2, 5'd5, 0, 32'h0,  0);
        for (int r = 0; r < 2; r++) begin
            add(0, 1, 0, 32'h0, 0, 2'd3, 5'd5, 0, 32'h0, 0);
            for (int i = 0; i < 5; i++)
                add(0, 0, 0, 32'h0, 0, 2'd3, 5'd5, 1, 32'h10 + 32'(i), 1'(i == 4));
            add(0, 0, 0, 32'h0, 0, 2'd2, 5'd5, 0, 32'h0, 0);
        end

        tick();
        tick();
        chk_status("reset", 2'd0, 5'd0, 1'b0);
        chk("reset_tvalid", 32'(bus.M_AXIS_TVALID), 32'd0);
        chk("reset_tlast", 32'(bus.M_AXIS_TLAST), 32'd0);
        chk("tstrb", 32'(bus.M_AXIS_TSTRB), 32'hF);
        rst = 1'b0;

        foreach (tbl[i]) begin
            cyc(tbl[i].arm, tbl[i].rs, tbl[i].tv, tbl[i].td, tbl[i].tl);
            chk_status($sformatf("vec%0d", i), tbl[i].st, tbl[i].cnt, tbl[i].ovf);
            chk($sformatf("vec%0d_tvalid", i), 32'(bus.M_AXIS_TVALID), 32'(tbl[i].ov));
            if (tbl[i].ov) begin
                chk($sformatf("vec%0d_tdata", i), bus.M_AXIS_TDATA, tbl[i].od);
                chk($sformatf("vec%0d_tlast", i), 32'(bus.M_AXIS_TLAST), 32'(tbl[i].ol));
            end
        end

        // Overflow: 20 beats, no TLAST.
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk("ovf_tready", 32'(bus.S_AXIS_TREADY), 32'd1);
            cyc(1'b0, 1'b0, 1'b1, 32'(i), 1'b0);
        end
        chk_status("ovf", 2'd2, 5'd16, 1'b1);
        readout(0, DEPTH);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(32'(i));
        cmp_pkt("ovf_pkt", exp_q);

        // Reset after 3 words of a readout.
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
        hs = 0;
        guard = 0;
        while (hs < 3 && guard < 20) begin
            if (bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) hs++;
            if (hs < 3) tick();
            guard++;
        end
        tick();
        chk("rst_words", 32'(hs), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_status("rst_mid", 2'd0, 5'd0, 1'b0);
        chk("rst_mid_tvalid", 32'(bus.M_AXIS_TVALID), 32'd0);
        chk("rst_mid_tlast", 32'(bus.M_AXIS_TLAST), 32'd0);

        // Backpressure on an 8-word packet.
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'hA0 + 32'(i));
            cyc(1'b0, 1'b0, 1'b1, 32'hA0 + 32'(i), 1'(i == 7));
        end
        chk_status("bp", 2'd2, 5'd8, 1'b0);
        readout(1, 8);
        cmp_pkt("bp_pkt", exp_q);

        // Control corners: arm beats readout_start; re-arm mid-capture.
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);
        chk_status("arm_wins", 2'd1, 5'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk_status("armed_rs_ignored", 2'd1, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 32'hC0 + 32'(i), 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'hDEAD, 1'b1);
        chk_status("rearm", 2'd1, 5'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h66, 1'b1);
        chk_status("rearm_done", 2'd2, 5'd2, 1'b0);
        readout(0, 2);
        exp_q.delete();
        exp_q.push_back(32'h55);
        exp_q.push_back(32'h66);
        cmp_pkt("rearm_pkt", exp_q);

        // Random packets against a queue model of what the buffer should keep.
        for (int it = 0; it < 12; it++) begin
            len      = int'($urandom_range(1, 20));
            has_last = 1'($urandom_range(0, 1));
            if (!has_last && len < DEPTH) len = DEPTH + int'($urandom_range(0, 4));
            for (int k = 0; k < 2; k++) cyc(1'b0, 1'b0, 1'b1, $urandom, 1'($urandom_range(0, 1)));
            cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
            sent.delete();
            for (int k = 0; k < len; k++) begin
                while ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, 1'b0, $urandom, 1'b1);
                d = $urandom;
                sent.push_back(d);
                cyc(1'b0, 1'b0, 1'b1, d, 1'(has_last && k == len - 1));
            end
            n       = (has_last && len < DEPTH) ? len : DEPTH;
            exp_ovf = !(has_last && len <= DEPTH);
            exp_q.delete();
            for (int k = 0; k < n; k++) exp_q.push_back(sent[k]);
            chk_status($sformatf("rnd%0d", it), 2'd2, 5'(n), exp_ovf);
            readout(2, n);
            cmp_pkt($sformatf("rnd%0d_pkt", it), exp_q);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
